// File: rtl/run_serializer_pkg.sv
// run_serializer_pkg: shared types and constants for the run serializer.
//   - ser_state_t   : serializer FSM states (IDLE, SEND)
//   - model_state_t : shadow detector model states (S0, S1, S2)
//   - RUN_LEN_W     : default width of the run-length field
package run_serializer_pkg;

    localparam int unsigned RUN_LEN_W = 4;

    typedef enum logic {
        IDLE,
        SEND
    } ser_state_t;

    typedef enum logic [1:0] {
        S0,
        S1,
        S2
    } model_state_t;

endpackage

// File: rtl/run_expect_model.sv
// run_expect_model: shadow model of the serial-X sequence detector.
// It counts consecutive ones on x (saturating at S2). Any zero on x
// returns it to S0. It flags a zero (Z1) or a one (Z2) that arrives
// after two or more ones.
// Ports:
//   clk     in  clock, rising edge
//   reset   in  synchronous, active-high
//   x       in  serial input (the serializer's x_out)
//   exp_z1  out Mealy: state S2 and x == 0
//   exp_z2  out Mealy: state S2 and x == 1
module run_expect_model
    import run_serializer_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic x,
    output logic exp_z1,
    output logic exp_z2
);

    model_state_t r_ps;
    model_state_t w_ns;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ps <= S0;
        end else begin
            r_ps <= w_ns;
        end
    end

    always_comb begin
        w_ns = r_ps;
        if (!x) begin
            w_ns = S0;
        end else begin
            unique case (r_ps)
                S0:      w_ns = S1;
                S1:      w_ns = S2;
                S2:      w_ns = S2;
                default: w_ns = S0;
            endcase
        end
    end

    assign exp_z1 = (r_ps == S2) && !x;
    assign exp_z2 = (r_ps == S2) && x;

endmodule

// File: rtl/run_serializer.sv
// run_serializer: turns (bit, length) run commands into a one-bit-per-cycle
// serial stream. Runs are chained with no gap cycles, and the line idles at 0.
// Optional feature macro: RUN_SERIALIZER_EXPECT_EN adds a shadow detector model
// that drives exp_z1/exp_z2. Without it those ports are tied to 0.
// Ports:
//   clk        in  clock, rising edge
//   reset      in  synchronous, active-high
//   cmd_valid  in  run command offered
//   cmd_ready  out command can be accepted this cycle
//   cmd_bit    in  value to drive for the run
//   cmd_len    in  run length in cycles (0 = discard)
//   x_out      out serial stream, registered
//   busy       out a run is being driven
//   run_done   out final bit cycle of the current run
//   exp_z1     out predicted detector Z1
//   exp_z2     out predicted detector Z2
module run_serializer
    import run_serializer_pkg::*;
#(
    parameter int unsigned LEN_W = RUN_LEN_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_bit,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             x_out,
    output logic             busy,
    output logic             run_done,
    output logic             exp_z1,
    output logic             exp_z2
);

    localparam logic [LEN_W-1:0] LenOne = LEN_W'(1);

    ser_state_t       r_ps;
    ser_state_t       w_ns;
    logic [LEN_W-1:0] r_remain;
    logic [LEN_W-1:0] w_remain;
    logic             r_bit;
    logic             w_bit;
    logic             r_x;
    logic             w_x;
    logic             w_last;
    logic             w_accept;
    logic             w_load;

    assign w_last    = (r_remain == LenOne);
    assign busy      = (r_ps == SEND);
    assign run_done  = busy && w_last;
    // Accepting on the last bit cycle is what makes back-to-back runs seamless.
    assign cmd_ready = (r_ps == IDLE) || run_done;
    assign w_accept  = cmd_valid && cmd_ready;
    // Zero-length commands are consumed but never start a run.
    assign w_load    = w_accept && (cmd_len != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ps     <= IDLE;
            r_remain <= '0;
            r_bit    <= 1'b0;
            r_x      <= 1'b0;
        end else begin
            r_ps     <= w_ns;
            r_remain <= w_remain;
            r_bit    <= w_bit;
            r_x      <= w_x;
        end
    end

    always_comb begin
        w_ns     = r_ps;
        w_remain = r_remain;
        w_bit    = r_bit;
        unique case (r_ps)
            IDLE: begin
                if (w_load) begin
                    w_ns     = SEND;
                    w_remain = cmd_len;
                    w_bit    = cmd_bit;
                end
            end
            SEND: begin
                if (!w_last) begin
                    w_remain = r_remain - LenOne;
                end else if (w_load) begin
                    w_remain = cmd_len;
                    w_bit    = cmd_bit;
                end else begin
                    w_ns     = IDLE;
                    w_remain = '0;
                end
            end
        endcase
        // x_out is registered from the next state so it lines up with busy.
        w_x = (w_ns == SEND) && w_bit;
    end

    assign x_out = r_x;

`ifdef RUN_SERIALIZER_EXPECT_EN
    run_expect_model u_expect_model (
        .clk    (clk),
        .reset  (reset),
        .x      (r_x),
        .exp_z1 (exp_z1),
        .exp_z2 (exp_z2)
    );
`else
    assign exp_z1 = 1'b0;
    assign exp_z2 = 1'b0;
`endif

endmodule

// File: tb/tb_run_serializer.sv
// tb_run_serializer: directed bench for run_serializer.
// The reference model keeps a queue of the bits still to be emitted, plus a
// two-deep history of x for the detector flags.
module tb_run_serializer;

    localparam int unsigned LEN_W = 4;

    logic             clk;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_bit;
    logic [LEN_W-1:0] cmd_len;
    logic             x_out;
    logic             busy;
    logic             run_done;
    logic             exp_z1;
    logic             exp_z2;

    run_serializer #(
        .LEN_W (LEN_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_bit   (cmd_bit),
        .cmd_len   (cmd_len),
        .x_out     (x_out),
        .busy      (busy),
        .run_done  (run_done),
        .exp_z1    (exp_z1),
        .exp_z2    (exp_z2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Model: pending stream bits, with a flag on the last bit of each run.
    bit q_bit[$];
    bit q_last[$];
    bit h1 = 1'b0;  // x one cycle ago
    bit h2 = 1'b0;  // x two cycles ago

    function automatic bit m_x();
        return (q_bit.size() != 0) ? q_bit[0] : 1'b0;
    endfunction

    always @(posedge clk) begin
        bit ready;
        if (reset) begin
            q_bit.delete();
            q_last.delete();
            h1 = 1'b0;
            h2 = 1'b0;
        end else begin
            ready = (q_bit.size() <= 1);
            h2 = h1;
            h1 = m_x();
            if (q_bit.size() != 0) begin
                void'(q_bit.pop_front());
                void'(q_last.pop_front());
            end
            if (cmd_valid && ready && cmd_len != 0) begin
                for (int i = 1; i <= int'(cmd_len); i++) begin
                    q_bit.push_back(cmd_bit);
                    q_last.push_back(i == int'(cmd_len));
                end
            end
        end
    end

    task automatic chk(input string name, input logic act, input logic req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at %0t: got %b, required %b", name, $time, act, req);
        end
    endtask

    // Compare process: all DUT outputs against the model, every cycle.
    always @(negedge clk) begin
        bit ex;
        bit ez1;
        bit ez2;
        if (chk_en) begin
            ex = m_x();
            ez1 = 1'b0;
            ez2 = 1'b0;
`ifdef RUN_SERIALIZER_EXPECT_EN
            ez1 = !ex && h1 && h2;
            ez2 = ex && h1 && h2;
`endif
            chk("model_x_out", x_out, ex);
            chk("model_busy", busy, q_bit.size() != 0);
            chk("model_run_done", run_done, (q_bit.size() != 0) && q_last[0]);
            chk("model_cmd_ready", cmd_ready, q_bit.size() <= 1);
            chk("model_exp_z1", exp_z1, ez1);
            chk("model_exp_z2", exp_z2, ez2);
        end
    end

    // Present inputs, then move to the middle of the next cycle.
    task automatic drive(input logic v, input logic b, input logic [LEN_W-1:0] l);
        cmd_valid = v;
        cmd_bit   = b;
        cmd_len   = l;
        @(negedge clk);
    endtask

    logic z_on;

    initial begin
`ifdef RUN_SERIALIZER_EXPECT_EN
        z_on = 1'b1;
`else
        z_on = 1'b0;
`endif
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_bit   = 1'b0;
        cmd_len   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_x_out", x_out, 1'b0);
        chk("reset_cmd_ready", cmd_ready, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk_en = 1'b1;
        reset  = 1'b0;

        // Idle for 5 cycles.
        repeat (5) @(negedge clk);

        // Single run (1, 3).
        drive(1'b1, 1'b1, 4'd3);
        cmd_valid = 1'b0;
        chk("single_c1_x", x_out, 1'b1);
        chk("single_c1_ready", cmd_ready, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("single_c3_done", run_done, 1'b1);
        chk("single_c3_z2", exp_z2, z_on);
        @(negedge clk);
        chk("single_c4_x", x_out, 1'b0);
        chk("single_c4_z1", exp_z1, z_on);
        chk("single_c4_busy", busy, 1'b0);
        repeat (2) @(negedge clk);

        // Back-to-back (1, 2) then (0, 4).
        drive(1'b1, 1'b1, 4'd2);
        chk("b2b_c1_x", x_out, 1'b1);
        chk("b2b_c1_ready", cmd_ready, 1'b0);
        cmd_bit = 1'b0;
        cmd_len = 4'd4;
        @(negedge clk);
        chk("b2b_c2_x", x_out, 1'b1);
        chk("b2b_c2_done", run_done, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("b2b_c3_x", x_out, 1'b0);
        chk("b2b_c3_busy", busy, 1'b1);
        repeat (2) @(negedge clk);
        chk("b2b_c5_busy", busy, 1'b1);
        @(negedge clk);
        chk("b2b_c6_done", run_done, 1'b1);
        @(negedge clk);
        chk("b2b_c7_busy", busy, 1'b0);
        repeat (2) @(negedge clk);

        // Zero-length command is consumed and discarded.
        drive(1'b1, 1'b1, 4'd0);
        cmd_valid = 1'b0;
        chk("zero_x", x_out, 1'b0);
        chk("zero_busy", busy, 1'b0);
        chk("zero_done", run_done, 1'b0);
        repeat (2) @(negedge clk);

        // Maximum run (1, 15).
        drive(1'b1, 1'b1, 4'd15);
        cmd_valid = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            chk("max_x", x_out, 1'b1);
            chk("max_z2", exp_z2, z_on && (i >= 3));
            @(negedge clk);
        end
        chk("max_end_x", x_out, 1'b0);
        chk("max_end_z1", exp_z1, z_on);
        repeat (2) @(negedge clk);

        // Reset on the 2nd cycle of a len=6 run, with a command offered during reset.
        drive(1'b1, 1'b1, 4'd6);
        cmd_valid = 1'b0;
        @(negedge clk);
        reset     = 1'b1;
        cmd_valid = 1'b1;
        cmd_bit   = 1'b1;
        cmd_len   = 4'd2;
        @(negedge clk);
        chk("rst_mid_x", x_out, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_ready", cmd_ready, 1'b1);
        chk("rst_mid_z1", exp_z1, 1'b0);
        reset     = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("rst_after_busy", busy, 1'b0);

        // A new run after reset behaves normally.
        drive(1'b1, 1'b0, 4'd2);
        cmd_valid = 1'b0;
        chk("post_rst_busy", busy, 1'b1);
        chk("post_rst_x", x_out, 1'b0);
        repeat (2) @(negedge clk);
        drive(1'b1, 1'b1, 4'd3);
        cmd_valid = 1'b0;
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/run_serializer.md
# run_serializer

- Stimulus source for the serial-X sequence detector: encodes run commands (bit value, run length) into a one-bit-per-cycle serial stream `x_out`.
- Upstream logic hands it runs over a valid/ready handshake.
- Runs stream back-to-back with no gap cycles; the line idles at 0.
- An optional shadow model predicts the detector's Z1/Z2 outputs cycle-aligned, so a bench can compare them directly.

## Interface
Parameters:
- LEN_W, 4, width of run-length field; max run = 2^LEN_W − 1 bits

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  run command offered
- cmd_ready  out  1  serializer can accept a command this cycle
- cmd_bit  in  1  value to drive for the run
- cmd_len  in  LEN_W  run length in cycles
- x_out  out  1  serial stream, registered
- busy  out  1  a run is being driven
- run_done  out  1  high during the final bit cycle of each run
- exp_z1  out  1  predicted detector Z1 (only with macro)
- exp_z2  out  1  predicted detector Z2 (only with macro)

## Operation
- FSM states:
  - IDLE: x_out=0, busy=0.
  - SEND: x_out=held bit, busy=1.
- Counter `remain` (LEN_W bits) holds the bits left, including the current one.
- Accept: cmd_valid && cmd_ready at a rising edge.
- cmd_ready = (ps==IDLE) || (ps==SEND && remain==1).
- IDLE + accept, cmd_len≠0: go to SEND; load bit=cmd_bit, remain=cmd_len.
- IDLE + accept, cmd_len==0: command consumed and discarded; stay IDLE; no run_done.
- SEND, remain>1: decrement remain.
- SEND, remain==1, no accept (or accept with cmd_len==0): go to IDLE.
- SEND, remain==1 + accept with cmd_len≠0: stay SEND; reload bit and remain. This gives a seamless back-to-back run.
- run_done = (ps==SEND && remain==1).
- cmd_bit/cmd_len are ignored when no accept occurs.
- Input hold: upstream keeps its command stable until accepted. The block does not check this.

## Timing
- Reset values: ps=IDLE, remain=0, x_out=0, busy=0, run_done=0, cmd_ready=1. With the macro: exp_z1=0, exp_z2=0, model state=S0.
- Latency: command accepted at edge k → x_out=cmd_bit from cycle after edge k for exactly cmd_len cycles.
- Back-to-back: the second run's first bit follows the first run's last bit in the next cycle; zero idle cycles.
- Reset mid-run: the in-flight run is dropped and all outputs return to reset values on the next edge.
- A command presented during reset is not accepted.
- Width: remain never underflows. Loading cmd_len = 2^LEN_W−1 gives the maximum run.

## Configuration
- Macro: RUN_SERIALIZER_EXPECT_EN.

Defined:
- A shadow model of the detector is instantiated. It has states S0/S1/S2, advanced each edge from x_out:
  - x_out=0 → S0
  - S0→S1
  - S1→S2
  - S2→S2
- exp_z1 = (model==S2) && !x_out.
- exp_z2 = (model==S2) && x_out.
- These are combinational (Mealy), matching a detector whose X is wired to x_out and which shares clk/reset.

Undefined:
- No model logic.
- exp_z1 and exp_z2 are tied to 0.
- The ports remain present.

## Structure
- Package run_serializer_pkg holds:
  - the serializer state enum (IDLE, SEND)
  - the model state enum (S0, S1, S2)
  - default constant RUN_LEN_W=4
- Sub-module run_expect_model: the shadow detector model. Inputs clk, reset, x; outputs exp_z1, exp_z2. Instantiated only under the macro.

## Test plan
- Reset then idle 5 cycles → x_out=0, busy=0, cmd_ready=1 throughout; exp_z1=exp_z2=0.
- Single run bit=1, len=3 accepted at edge k → x_out=1 for 3 cycles, run_done on the 3rd, then x_out=0. Expected flags:
  - exp_z2=1 on the 3rd bit cycle
  - exp_z1=1 on the first 0 cycle after the run
- Back-to-back: (1,2) then (0,4) offered continuously → x_out = 1,1,0,0,0,0 with no gap. The second command is accepted on the edge ending the run_done cycle of the first. cmd_ready is low on the first bit cycle of run 1.
- cmd_len=0 with bit=1 in IDLE → command consumed; x_out stays 0; no run_done; busy stays 0.
- Max run: bit=1, len=15 → x_out=1 for exactly 15 cycles; exp_z2=1 on cycles 3..15.
- Reset asserted on the 2nd cycle of a len=6 run → next cycle x_out=0, busy=0, cmd_ready=1, model in S0. A new run afterward behaves normally.
